// File: rtl/toggle_cover_detector.sv
// Per-bit toggle-coverage detector: flags each bit once it has both risen and
// fallen, then emits one-cycle valid pulses, lowest index first, at most MAX_EMIT per cycle.
module toggle_cover_detector #(
    parameter int WIDTH    = 16,
    parameter int MAX_EMIT = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               sig,
    input  logic                           clear,
    output logic [WIDTH-1:0]               valid,
    output logic [$clog2(WIDTH+1)-1:0]     hit_count,
    output logic                           all_covered,
    output logic                           busy
);
    localparam int CW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] r_prev;
    logic             r_armed;
    logic [WIDTH-1:0] r_rose;
    logic [WIDTH-1:0] r_fell;
    logic [WIDTH-1:0] r_covered;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_valid;
    logic [CW-1:0]    r_hit_count;
    logic             r_all_covered;
    logic             r_busy;

    logic [WIDTH-1:0] w_rose_next;
    logic [WIDTH-1:0] w_fell_next;
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_covered_next;
    logic [WIDTH-1:0] w_cand;
    logic [WIDTH-1:0] w_sel;
    logic [CW-1:0]    w_hit_count_next;
    logic [WIDTH:0][CW-1:0] w_before;

    // Transitions only count once prev holds a genuine sample.
    assign w_rose_next    = r_armed ? (r_rose | (~r_prev & sig)) : r_rose;
    assign w_fell_next    = r_armed ? (r_fell | (r_prev & ~sig)) : r_fell;
    assign w_new          = w_rose_next & w_fell_next & ~r_covered;
    assign w_covered_next = r_covered | w_new;
    assign w_cand         = r_pending | w_new;

    // w_before[i] counts candidate bits below index i; the first MAX_EMIT win.
    assign w_before[0] = '0;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign w_before[gi+1] = w_before[gi] + {{(CW-1){1'b0}}, w_cand[gi]};
            assign w_sel[gi]      = w_cand[gi] & (w_before[gi] < CW'(MAX_EMIT));
        end
    endgenerate

    always_comb begin
        w_hit_count_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_hit_count_next = w_hit_count_next + {{(CW-1){1'b0}}, w_covered_next[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev        <= '0;
            r_armed       <= 1'b0;
            r_rose        <= '0;
            r_fell        <= '0;
            r_covered     <= '0;
            r_pending     <= '0;
            r_valid       <= '0;
            r_hit_count   <= '0;
            r_all_covered <= 1'b0;
            r_busy        <= 1'b0;
        end else if (clear) begin
            // Re-arm: same-cycle hits are dropped, but the sample is kept.
            r_prev        <= sig;
            r_armed       <= 1'b0;
            r_rose        <= '0;
            r_fell        <= '0;
            r_covered     <= '0;
            r_pending     <= '0;
            r_valid       <= '0;
            r_hit_count   <= '0;
            r_all_covered <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_prev        <= sig;
            r_armed       <= 1'b1;
            r_rose        <= w_rose_next;
            r_fell        <= w_fell_next;
            r_covered     <= w_covered_next;
            r_pending     <= w_cand & ~w_sel;
            r_valid       <= w_sel;
            r_hit_count   <= w_hit_count_next;
            r_all_covered <= &w_covered_next;
            r_busy        <= |(w_cand & ~w_sel);
        end
    end

    assign valid       = r_valid;
    assign hit_count   = r_hit_count;
    assign all_covered = r_all_covered;
    assign busy        = r_busy;
endmodule

// File: tb/tb_toggle_cover_detector.sv
// Directed bench for toggle_cover_detector: hand-computed valid/hit_count/busy
// sequences for burst drain, once-only, index priority, clear and reset cases.
module tb_toggle_cover_detector;
    logic        clock;
    logic        reset;
    logic [15:0] sig;
    logic        clear;
    logic [15:0] valid;
    logic [4:0]  hit_count;
    logic        all_covered;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    toggle_cover_detector #(.WIDTH(16), .MAX_EMIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .sig         (sig),
        .clear       (clear),
        .valid       (valid),
        .hit_count   (hit_count),
        .all_covered (all_covered),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Apply inputs, take one rising edge, return at the following falling edge.
    task automatic step(input logic [15:0] s, input logic clr, input logic rst);
        sig   = s;
        clear = clr;
        reset = rst;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        reset = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] v, input logic [4:0] hc,
                              input logic ac, input logic b);
        check({tag, ".valid"},       32'(valid),       32'(v));
        check({tag, ".hit_count"},   32'(hit_count),   32'(hc));
        check({tag, ".all_covered"}, 32'(all_covered), 32'(ac));
        check({tag, ".busy"},        32'(busy),        32'(b));
    endtask

    task automatic do_reset();
        step(16'h0000, 1'b0, 1'b1);
    endtask

    task automatic burst_start();
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("burst_arm", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("burst_fall", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("burst_p1", 16'h000F, 5'd16, 1'b1, 1'b1);
    endtask

    initial begin
        sig   = 16'h0000;
        clear = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        // Reset state
        do_reset();
        expect_out("reset", 16'h0000, 5'd0, 1'b0, 1'b0);

        // Burst drain
        burst_start();
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("burst_p2", 16'h00F0, 5'd16, 1'b1, 1'b1);
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("burst_p3", 16'h0F00, 5'd16, 1'b1, 1'b1);
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("burst_p4", 16'hF000, 5'd16, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("burst_idle", 16'h0000, 5'd16, 1'b1, 1'b0);

        // Single bit, once only
        do_reset();
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b0);
        expect_out("b3_rise", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("b3_hit", 16'h0008, 5'd1, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("b3_after", 16'h0000, 5'd1, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("b3_retoggle", 16'h0000, 5'd1, 1'b0, 1'b0);

        // Index priority: bits 2-5 and 8-15 hit together, bits 0-1 hit during drain
        do_reset();
        step(16'h0000, 1'b0, 1'b0);
        step(16'hFF3F, 1'b0, 1'b0);
        step(16'h0003, 1'b0, 1'b0);
        expect_out("prio_p1", 16'h003C, 5'd12, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("prio_p2", 16'h0303, 5'd14, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("prio_p3", 16'h3C00, 5'd14, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("prio_p4", 16'hC000, 5'd14, 1'b0, 1'b0);

        // Clear mid-drain
        do_reset();
        burst_start();
        step(16'hFFFF, 1'b1, 1'b0);
        expect_out("clr_mid", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0001, 1'b0, 1'b0);
        expect_out("clr_arm", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("clr_fall", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0001, 1'b0, 1'b0);
        expect_out("clr_rehit", 16'h0001, 5'd1, 1'b0, 1'b0);

        // Clear beats same-cycle hit
        do_reset();
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0004, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        expect_out("clr_same", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("clr_same_next", 16'h0000, 5'd0, 1'b0, 1'b0);

        // Reset mid-drain, and the first post-reset sample sets no rose flags
        do_reset();
        burst_start();
        step(16'hFFFF, 1'b1, 1'b1);
        expect_out("rst_mid", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("rst_arm", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        expect_out("rst_norose", 16'h0000, 5'd0, 1'b0, 1'b0);
        step(16'hFFFF, 1'b0, 1'b0);
        expect_out("rst_rehit", 16'h000F, 5'd16, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/toggle_cover_detector.md
# toggle_cover_detector

Per-bit toggle-coverage detector that sits directly upstream of the `GEN_w*_toggle` DPI reporters. It watches a vector of design signals and records, per bit, whether both a 0→1 and a 1→0 transition have occurred. It drives a one-cycle `valid` pulse exactly once per bit when that bit first completes a full toggle. Emission is throttled to at most `MAX_EMIT` pulses per cycle; hits beyond the limit are buffered in a pending mask, so DPI call bursts stay bounded.

## Interface
- `WIDTH`, 16, number of watched bits; equals the width of the downstream reporter's `valid`.
- `MAX_EMIT`, 4, maximum number of `valid` bits asserted in one cycle (1..WIDTH).
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `sig` input WIDTH: watched signals, sampled every rising edge.
- `clear` input 1: synchronous re-arm; discards all coverage state.
- `valid` output WIDTH: one-cycle hit pulses; connects to the reporter's `valid`.
- `hit_count` output $clog2(WIDTH+1): number of bits covered so far (5 bits for WIDTH=16).
- `all_covered` output 1: high when every bit is covered.
- `busy` output 1: high when the pending mask is non-zero.

## Operation
- State registers:
  - `prev[WIDTH]`: last sample of `sig`.
  - `armed`: 1 once `prev` holds a real sample.
  - `rose[WIDTH]`, `fell[WIDTH]`: sticky transition flags.
  - `covered[WIDTH]`: sticky full-toggle flags.
  - `pending[WIDTH]`: covered bits not yet emitted.
  - Output registers for `valid`, `hit_count`, `all_covered`, `busy`.
- Every edge, with `prev <= sig` always:
  - If `armed`:
    - `rose |= ~prev & sig`
    - `fell |= prev & ~sig`
  - `armed <= 1`.
- New hits: `new = (rose_next & fell_next) & ~covered`; then `covered |= new`.
- Emission:
  - `cand = pending | new`.
  - `sel` = the lowest-index set bits of `cand`, at most `MAX_EMIT` of them.
  - `valid <= sel`, `pending <= cand & ~sel`.
  - Priority is strictly by bit index. A fresh hit can overtake an older pending bit only if it has the lower index.
- A bit is emitted exactly once between clears or resets. Later toggles of a covered bit are ignored.
- `hit_count <= popcount(covered_next)`. It counts at completion, not at emission.
- `all_covered <= &covered_next`.
- `busy <= |(cand & ~sel)`.
- `clear` (when `reset` is low):
  - Zeroes `rose`, `fell`, `covered`, `pending`, `valid`, `hit_count`, `all_covered`, `busy`.
  - Sets `armed <= 0`.
  - Still loads `prev <= sig`.
  - Takes priority over any transition or hit in the same cycle; such hits are lost.
- Reset: zeroes all registers, including `prev` and `armed`. Every output reads 0 in the cycle after reset. Reset takes priority over `clear`.
- Reset or clear in mid-drain discards pending bits; they are never emitted.
- No arithmetic overflow: `hit_count` saturates naturally at WIDTH.

## Timing
- Latency: a toggle completed by the sample at edge k pulses `valid` in the cycle following edge k, if it is selected then.
- Each subsequent deferral adds one cycle.
- Worst-case drain after a WIDTH-bit burst: ceil(WIDTH/MAX_EMIT) cycles (4 for the defaults).
- First sample after reset or clear only loads `prev`; it never produces a transition.
- `valid` bits are high for exactly one cycle. There is no backpressure; the downstream consumes unconditionally.
- `popcount(valid) <= MAX_EMIT` every cycle.

## Test plan
- **Burst drain:**
  - Stimulus: reset, then `sig` = 0xFFFF, 0x0000, 0xFFFF on consecutive edges.
  - No hit on the first sample (`armed` = 0).
  - After the third edge: `hit_count` = 16 and `all_covered` = 1 immediately.
  - `valid` = 0x000F, 0x00F0, 0x0F00, 0xF000 on successive cycles.
  - `busy` falls with the last pulse.
- **Single bit, once only:**
  - Stimulus: bit 3 driven 0,0,1,0 (other bits 0).
  - `valid` = 0x0008 for one cycle, `hit_count` = 1.
  - Further toggles of bit 3 produce no `valid`.
- **Index priority:**
  - Stimulus: complete toggles on bits 8–15, then on bits 0–1 during the drain.
  - Next emission = 0x0303 (bits 0, 1, 8, 9), followed by 0x3C00, then 0xC000.
- **Clear mid-drain:**
  - Stimulus: run the burst-drain case and assert `clear` after the first pulse.
  - Next cycle: `valid` = 0, `hit_count` = 0, `busy` = 0, `all_covered` = 0.
  - A later 1,0,1 pattern on bit 0 re-emits 0x0001.
- **Clear beats same-cycle hit:**
  - Stimulus: bit 2 completes its toggle on the same edge `clear` is high.
  - No `valid`, `hit_count` = 0.
- **Reset mid-drain:**
  - Stimulus: assert `reset` while `busy` = 1.
  - Cycle after: all outputs 0.
  - The first post-reset sample of `sig` = 0xFFFF produces no `rose` flags.
